// File: rtl/range_pkg.sv
// range_pkg: shared types and widths for the range-finder front end
package range_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_FIRST, STREAM, DONE} framer_state_t;
  localparam int SAMPLE_W = 10;
endpackage

// File: rtl/sipo_shifter.sv
// sipo_shifter: serial-to-parallel shifter with word-boundary bit counter
module sipo_shifter #(
  parameter int W = 10,
  parameter bit MSB_FIRST = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         shift_en,
  input  logic         clr,
  input  logic         din,
  output logic [W-1:0] q,
  output logic         word_done,
  output logic         partial
);
  localparam int CW = $clog2(W);
  logic [W-1:0] sh;
  logic [CW-1:0] cnt;
  assign q = MSB_FIRST ? {sh[W-2:0], din} : {din, sh[W-1:1]};
  assign word_done = shift_en && cnt == CW'(W - 1);
  assign partial = cnt != '0;
  // shift in accepted bits; counter wraps on word completion, clear drops partial bits
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      sh <= '0;
      cnt <= '0;
    end else if (clr) begin
      sh <= '0;
      cnt <= '0;
    end else if (shift_en) begin
      sh <= q;
      cnt <= word_done ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/range_sample_framer.sv
// range_sample_framer: deframes serial samples into words with go/finish strobes
module range_sample_framer
  import range_pkg::*;
#(
  parameter int W = SAMPLE_W,
  parameter bit MSB_FIRST = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         ser_data,
  input  logic         ser_valid,
  input  logic         frame,
  output logic [W-1:0] data_out,
  output logic         go,
  output logic         finish,
  output logic         frame_error,
  output logic         busy
);
  framer_state_t state, state_n;
  logic [W-1:0] word;
  logic word_done, partial, go_n, fin_n, err_n;
  sipo_shifter #(.W(W), .MSB_FIRST(MSB_FIRST)) u_sipo (
    .clock(clock),
    .reset(reset),
    .shift_en(ser_valid & frame),
    .clr(~frame),
    .din(ser_data),
    .q(word),
    .word_done(word_done),
    .partial(partial)
  );
  assign busy = state != IDLE;
  // burst sequencing and strobe decisions
  always_comb begin
    state_n = state;
    go_n = 1'b0;
    fin_n = 1'b0;
    err_n = 1'b0;
    case (state)
      IDLE: state_n = frame ? WAIT_FIRST : IDLE;
      WAIT_FIRST:
        if (!frame) begin
          state_n = IDLE;
          err_n = 1'b1;
        end else if (word_done) begin
          state_n = STREAM;
          go_n = 1'b1;
        end
      STREAM:
        if (!frame) begin
          state_n = DONE;
          fin_n = 1'b1;
          err_n = partial;
        end
      DONE: state_n = frame ? WAIT_FIRST : IDLE;
      default: state_n = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  // output word and registered strobes
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      data_out <= '0;
      go <= 1'b0;
      finish <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      if (word_done) data_out <= word;
      go <= go_n;
      finish <= fin_n;
      frame_error <= err_n;
    end
endmodule

// File: tb/tb_range_sample_framer.sv
// tb_range_sample_framer: scoreboard bench with burst-level reference model
module tb_range_sample_framer;
  localparam int W = 10;
  logic clock = 0, reset = 0, ser_data = 0, ser_valid = 0, frame = 0;
  logic [W-1:0] data_out;
  logic go, finish, frame_error, busy;
  typedef struct {
    int cyc;
    logic [W-1:0] d;
    logic g, f, e;
  } rec_t;
  rec_t exp_q[$];
  bit bits[$];
  int checks = 0, errors = 0, cyc = 0;
  logic [W-1:0] model_data = '0, prev = '0, mx = '0, mn = '0;

  range_sample_framer #(.W(W), .MSB_FIRST(1)) dut (
    .clock(clock),
    .reset(reset),
    .ser_data(ser_data),
    .ser_valid(ser_valid),
    .frame(frame),
    .data_out(data_out),
    .go(go),
    .finish(finish),
    .frame_error(frame_error),
    .busy(busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endfunction

  task automatic drive(input logic f, input logic v, input logic d);
    frame = f;
    ser_valid = v;
    ser_data = d;
    @(posedge clock);
    #1;
  endtask

  function automatic void add_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) bits.push_back(w[i]);
  endfunction

  // Burst model: every W accepted bits form a word (MSB first); the first word
  // carries go; the end of the burst yields finish if any word completed and
  // frame_error if no word completed or leftover bits remain.
  task automatic burst(input int gap_pct, input int tail, input bit abort);
    int n = 0;
    logic [W-1:0] w = '0;
    if (bits.size() == 0) drive(1, 0, 1'($urandom));
    foreach (bits[i]) begin
      while ($urandom_range(99) < gap_pct) drive(1, 0, 1'($urandom));
      w = {w[W-2:0], bits[i]};
      n++;
      if (n % W == 0) begin
        if (n == W || w != model_data) exp_q.push_back('{cyc + 1, w, 1'(n == W), 1'b0, 1'b0});
        model_data = w;
      end
      drive(1, 1, bits[i]);
    end
    bits.delete();
    if (!abort) begin
      exp_q.push_back('{cyc + 1, model_data, 1'b0, 1'(n >= W), 1'(n < W || n % W != 0)});
      drive(0, 1'($urandom), 1'($urandom));
      repeat (tail) drive(0, 1'($urandom), 1'($urandom));
    end
  endtask

  // monitor: any strobe or data_out change must match the next expected record
  initial begin
    rec_t r;
    forever begin
      @(negedge clock);
      if (reset) prev = data_out;
      else if (go || finish || frame_error || data_out != prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event cyc %0d data %0h go %0b fin %0b err %0b want none",
                   cyc, data_out, go, finish, frame_error);
        end else begin
          r = exp_q.pop_front();
          chk("event_cycle", cyc, r.cyc);
          chk("data_out", int'(data_out), int'(r.d));
          chk("go", int'(go), int'(r.g));
          chk("finish", int'(finish), int'(r.f));
          chk("frame_error", int'(frame_error), int'(r.e));
          if (go) begin
            mx = data_out;
            mn = data_out;
          end else if (data_out != prev) begin
            if (data_out > mx) mx = data_out;
            if (data_out < mn) mn = data_out;
          end
        end
        prev = data_out;
      end
    end
  end

  initial begin
    int nb;
    #1 reset = 1;
    #1;
    chk("rst_data", int'(data_out), 0);
    chk("rst_go", int'(go), 0);
    chk("rst_finish", int'(finish), 0);
    chk("rst_err", int'(frame_error), 0);
    chk("rst_busy", int'(busy), 0);
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    reset = 0;
    drive(0, 0, 0);
    add_word(10'h155);
    burst(0, 2, 0);
    add_word(10'h020);
    add_word(10'h3F0);
    add_word(10'h005);
    burst(30, 2, 0);
    chk("range_max_min", int'(mx - mn), 'h3EB);
    add_word(10'h0AA);
    repeat (4) bits.push_back(1'($urandom));
    burst(0, 0, 0);
    add_word(10'h3C1);
    add_word(10'h11E);
    burst(0, 0, 0);
    add_word(10'h207);
    burst(20, 2, 0);
    repeat (6) bits.push_back(1'($urandom));
    burst(10, 2, 0);
    chk("idle_busy", int'(busy), 0);
    add_word(10'h2C3);
    repeat (5) bits.push_back(1'($urandom));
    burst(0, 0, 1);
    #2 reset = 1;
    #1;
    chk("async_rst_data", int'(data_out), 0);
    chk("async_rst_go", int'(go), 0);
    chk("async_rst_finish", int'(finish), 0);
    chk("async_rst_err", int'(frame_error), 0);
    chk("async_rst_busy", int'(busy), 0);
    model_data = '0;
    frame = 0;
    ser_valid = 0;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    reset = 0;
    repeat (4) drive(0, 1, 1);
    chk("post_rst_busy", int'(busy), 0);
    repeat (25) begin
      nb = $urandom_range(0, 35);
      repeat (nb) bits.push_back(1'($urandom));
      burst(25, $urandom_range(0, 2), 0);
    end
    repeat (5) drive(0, 0, 0);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/range_sample_framer.md
Name: range_sample_framer

Overview:
Upstream feeder for the range-finder chip. Deserializes a framed 1-bit sample stream into W-bit words, holds the latest completed word on data_out, and generates the go and finish strobes that drive the range finder's data_in, go and finish inputs. The signalling guarantees that go and finish are never asserted together and that finish is never asserted without a preceding go.

Parameters:
- W, 10, sample word width in bits; must equal the range-finder data width.
- MSB_FIRST, 1, 1 = first serial bit lands in data_out[W-1]; 0 = first bit lands in data_out[0].

Ports:
- clock  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- ser_data  input  1  serial sample bit; sampled only when ser_valid && frame
- ser_valid  input  1  bit strobe; one bit accepted per cycle it is high (with frame high)
- frame  input  1  burst envelope; high for the duration of one measurement burst
- data_out  output  W  last completed word; held stable between word completions
- go  output  1  registered, 1-cycle pulse coincident with the first word of a burst on data_out
- finish  output  1  registered, 1-cycle pulse at burst end when at least one word was emitted
- frame_error  output  1  registered, 1-cycle pulse when a burst ends on a partial word or with zero words
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async): state=IDLE, bit_cnt=0, shift register=0, data_out=0, go=0, finish=0, frame_error=0, busy=0.
- Bit accept: ser_valid && frame.
  - Shift register takes ser_data per MSB_FIRST.
  - bit_cnt increments; wraps W-1 -> 0 on word completion.
- Word completion: accept with bit_cnt==W-1.
  - data_out loads the completed word at that same clock edge.
  - The word is visible on data_out the next cycle.
- States:
  - IDLE:
    - frame=0 -> IDLE; bits ignored.
    - frame=1 -> WAIT_FIRST. The bit in that same cycle is accepted if ser_valid is high.
  - WAIT_FIRST (no word yet in this burst):
    - Word completion -> STREAM. Set go=1 for the following cycle, together with the new data_out.
    - frame=0 -> IDLE. frame_error pulses next cycle; no go, no finish; bit_cnt clears.
  - STREAM: each further completion updates data_out; no go, no finish.
    - frame=0 with bit_cnt==0 -> DONE. finish pulses next cycle.
    - frame=0 with bit_cnt!=0 -> DONE. finish and frame_error both pulse next cycle; partial bits are discarded and bit_cnt clears.
  - DONE (one cycle; finish is high here):
    - frame=1 -> WAIT_FIRST; a bit accept in this cycle counts.
    - frame=0 -> IDLE.
- Simultaneous events:
  - frame falling in the same cycle as ser_valid: frame is low, so the bit is ignored.
  - A word can never complete in the same cycle that frame falls.
- Between completions, data_out holds its value. The downstream re-comparing an unchanged sample is harmless (min/max are idempotent).
- data_out is not cleared at burst end; it is cleared only by reset.
- go and finish are mutually exclusive by construction.
- Reset mid-burst: immediate return to IDLE with all outputs 0. No finish or frame_error is generated.
- Consecutive bursts need at least one cycle with frame low between them (the DONE cycle).

Decomposition:
- Package range_pkg:
  - framer_state_t enum {IDLE, WAIT_FIRST, STREAM, DONE} (2 bits).
  - localparam SAMPLE_W = 10, shared with the range finder.
- Sub-module sipo_shifter #(W, MSB_FIRST):
  - Inputs: clock, reset, shift_en, clr, din.
  - Outputs: q[W-1:0] and a word_done flag from an internal bit counter.
- The top level holds the FSM, the data_out register and the strobe registers.

Test Plan (W=10, MSB_FIRST=1):
1. Frame high, 10 bits of 10'h155 with ser_valid held high, then frame low -> cycle after 10th bit: data_out=10'h155 and go=1 for exactly one cycle; finish=1 one cycle after frame falls; frame_error=0.
2. Burst with words 10'h020, 10'h3F0, 10'h005, bits separated by random ser_valid gaps -> data_out steps 020 -> 3F0 -> 005; go only with 020; single finish; the downstream range finder reads 10'h3EB.
3. Burst with 1 full word 10'h0AA plus 4 extra bits, then frame low -> finish=1 and frame_error=1 in the same cycle; data_out stays 10'h0AA; bit_cnt=0 for the next burst.
4. Frame high for 6 bits, then low -> frame_error=1 one cycle; go and finish never assert; returns to IDLE.
5. Assert reset after 15 bits mid-burst -> all outputs 0 immediately (async); after release with frame=0, no spurious go/finish/frame_error.
6. Back-to-back bursts with frame low for exactly one cycle (DONE), then high with ser_valid high in that cycle -> the bit is counted, the second burst's go arrives with its first word, and the two finish pulses are separated.
